// File: rtl/honeybee_issue_unit.sv
// Issue stage between the core controller and the HONEYBEE collision accelerator:
// snapshots edge operands, runs ap_start/ap_done with a bounded wait, returns the 64-bit result.
module honeybee_issue_unit #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [BUS_WIDTH-1:0]   i_e_in0,
  input  logic [BUS_WIDTH-1:0]   i_e_in1,
  input  logic [BUS_WIDTH-1:0]   i_e_in2,
  input  logic [BUS_WIDTH-1:0]   i_e_in3,
  input  logic [BUS_WIDTH-1:0]   i_e_in4,
  input  logic [BUS_WIDTH-1:0]   i_e_in5,
  output logic                   o_hb_start,
  input  logic                   i_hb_done,
  input  logic [2*BUS_WIDTH-1:0] i_hb_return,
  output logic [BUS_WIDTH-1:0]   o_hb_e0,
  output logic [BUS_WIDTH-1:0]   o_hb_e1,
  output logic [BUS_WIDTH-1:0]   o_hb_e2,
  output logic [BUS_WIDTH-1:0]   o_hb_e3,
  output logic [BUS_WIDTH-1:0]   o_hb_e4,
  output logic [BUS_WIDTH-1:0]   o_hb_e5,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [BUS_WIDTH-1:0]   o_resp_lo,
  output logic [BUS_WIDTH-1:0]   o_resp_hi,
  output logic                   o_timeout,
  output logic                   o_busy
);

  // state  | meaning
  // IDLE   | ready for a request
  // LAUNCH | operands latched, ap_start raised on exit
  // WAIT   | ap_start high, waiting for ap_done or expiry
  // RESP   | result held until the controller consumes it
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 r_hb_start;
  logic                 w_hb_start_nxt;
  logic                 r_resp_valid;
  logic                 w_resp_valid_nxt;
  logic [BUS_WIDTH-1:0] r_resp_lo;
  logic [BUS_WIDTH-1:0] w_resp_lo_nxt;
  logic [BUS_WIDTH-1:0] r_resp_hi;
  logic [BUS_WIDTH-1:0] w_resp_hi_nxt;
  logic                 r_timeout;
  logic                 w_timeout_nxt;
  logic                 r_req_ready;
  logic                 r_busy;
  logic                 w_latch;
  logic [BUS_WIDTH-1:0] r_hb_e [6];

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hb_start_nxt   = r_hb_start;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_lo_nxt    = r_resp_lo;
    w_resp_hi_nxt    = r_resp_hi;
    w_timeout_nxt    = r_timeout;
    w_latch          = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_hb_start_nxt = 1'b1;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        // ap_done takes priority over an expiry in the same cycle
        if (i_hb_done) begin
          w_resp_lo_nxt    = i_hb_return[BUS_WIDTH-1:0];
          w_resp_hi_nxt    = i_hb_return[2*BUS_WIDTH-1:BUS_WIDTH];
          w_timeout_nxt    = 1'b0;
          w_hb_start_nxt   = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = RESP;
        end else if (r_cnt == LP_LAST) begin
          w_resp_lo_nxt    = '0;
          w_resp_hi_nxt    = '0;
          w_timeout_nxt    = 1'b1;
          w_hb_start_nxt   = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_hb_start   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_lo    <= '0;
      r_resp_hi    <= '0;
      r_timeout    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      for (int i = 0; i < 6; i++) r_hb_e[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hb_start   <= w_hb_start_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_lo    <= w_resp_lo_nxt;
      r_resp_hi    <= w_resp_hi_nxt;
      r_timeout    <= w_timeout_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_busy       <= (w_state_nxt != IDLE);
      if (w_latch) begin
        r_hb_e[0] <= i_e_in0;
        r_hb_e[1] <= i_e_in1;
        r_hb_e[2] <= i_e_in2;
        r_hb_e[3] <= i_e_in3;
        r_hb_e[4] <= i_e_in4;
        r_hb_e[5] <= i_e_in5;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_busy       = r_busy;
  assign o_hb_start   = r_hb_start;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_lo    = r_resp_lo;
  assign o_resp_hi    = r_resp_hi;
  assign o_timeout    = r_timeout;
  assign o_hb_e0      = r_hb_e[0];
  assign o_hb_e1      = r_hb_e[1];
  assign o_hb_e2      = r_hb_e[2];
  assign o_hb_e3      = r_hb_e[3];
  assign o_hb_e4      = r_hb_e[4];
  assign o_hb_e5      = r_hb_e[5];

endmodule

// File: tb/tb_honeybee_issue_unit.sv
// Directed and randomized transactions for honeybee_issue_unit, checked against a
// transaction-level model of the request/start/done/response protocol.
module tb_honeybee_issue_unit;
  localparam int BW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          hb_done = 1'b0;
  logic          resp_ready = 1'b0;
  logic [BW-1:0] e_in0 = '0, e_in1 = '0, e_in2 = '0, e_in3 = '0, e_in4 = '0, e_in5 = '0;
  logic [2*BW-1:0] hb_return = '0;

  logic          req_ready, hb_start, resp_valid, timeout, busy;
  logic [BW-1:0] hb_e0, hb_e1, hb_e2, hb_e3, hb_e4, hb_e5, resp_lo, resp_hi;
  logic [6*BW-1:0] hbe;

  int n_checks = 0;
  int n_err = 0;
  logic [6*BW-1:0] e_cur;

  honeybee_issue_unit #(.BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_e_in0(e_in0), .i_e_in1(e_in1), .i_e_in2(e_in2),
    .i_e_in3(e_in3), .i_e_in4(e_in4), .i_e_in5(e_in5),
    .o_hb_start(hb_start), .i_hb_done(hb_done), .i_hb_return(hb_return),
    .o_hb_e0(hb_e0), .o_hb_e1(hb_e1), .o_hb_e2(hb_e2),
    .o_hb_e3(hb_e3), .o_hb_e4(hb_e4), .o_hb_e5(hb_e5),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_lo(resp_lo), .o_resp_hi(resp_hi), .o_timeout(timeout), .o_busy(busy)
  );

  assign hbe = {hb_e5, hb_e4, hb_e3, hb_e2, hb_e1, hb_e0};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input logic [6*BW-1:0] obs, input logic [6*BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_e(input logic [6*BW-1:0] v);
    e_in0 = v[0*BW +: BW];
    e_in1 = v[1*BW +: BW];
    e_in2 = v[2*BW +: BW];
    e_in3 = v[3*BW +: BW];
    e_in4 = v[4*BW +: BW];
    e_in5 = v[5*BW +: BW];
  endtask

  function automatic logic [6*BW-1:0] rand_e();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // done_at: WAIT cycle (1-based) in which ap_done pulses; 0 or beyond TO means never.
  task automatic run_txn(input logic [6*BW-1:0] ev, input int done_at,
                         input logic [63:0] ret, input int bp);
    int c;
    int hi;
    logic exp_to;
    int exp_hi;
    logic [63:0] exp_res;
    exp_to  = (done_at < 1) || (done_at > TO);
    exp_hi  = exp_to ? TO : done_at;
    exp_res = exp_to ? 64'h0 : ret;

    chk("idle_req_ready", 64'(req_ready), 64'd1);
    e_cur = ev;
    set_e(ev);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    set_e(rand_e());
    chk("launch_busy", 64'(busy), 64'd1);
    chk("launch_req_ready", 64'(req_ready), 64'd0);
    chk("launch_hb_start", 64'(hb_start), 64'd0);
    chk_e("launch_hb_e", hbe, e_cur);
    step();

    c = 1;
    hi = 0;
    while (!resp_valid && c <= TO + 2) begin
      if (hb_start) hi++;
      hb_done   = (c == done_at);
      hb_return = hb_done ? ret : {$urandom, $urandom};
      step();
      hb_done = 1'b0;
      c++;
    end
    chk("resp_valid_rise", 64'(resp_valid), 64'd1);
    chk("hb_start_cycles", 64'(hi), 64'(exp_hi));
    chk("hb_start_dropped", 64'(hb_start), 64'd0);
    chk("resp_word", {resp_hi, resp_lo}, exp_res);
    chk("resp_timeout", 64'(timeout), 64'(exp_to));
    chk("resp_req_ready", 64'(req_ready), 64'd0);
    chk_e("resp_hb_e", hbe, e_cur);

    for (int i = 0; i < bp; i++) begin
      set_e(rand_e());
      req_valid = 1'($urandom);
      hb_done   = 1'($urandom);
      hb_return = {$urandom, $urandom};
      step();
      chk("bp_resp", {resp_hi, resp_lo}, exp_res);
      chk("bp_valid_timeout", {62'd0, resp_valid, timeout}, {62'd0, 1'b1, exp_to});
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk_e("bp_hb_e", hbe, e_cur);
    end
    hb_done    = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("done_resp_valid", 64'(resp_valid), 64'd0);
    chk("done_req_ready", 64'(req_ready), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_ctrl", {60'd0, busy, hb_start, resp_valid, timeout}, 64'd0);
    chk("rst_resp", {resp_hi, resp_lo}, 64'd0);
    chk_e("rst_hb_e", hbe, '0);

    // basic: operands 1..6, done in the 5th WAIT cycle
    run_txn({32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 5, 64'hDEADBEEF_00000001, 0);
    // backpressure for 10 cycles
    run_txn(rand_e(), 3, {$urandom, $urandom}, 10);
    // timeout: ap_done never arrives
    run_txn(rand_e(), 0, {$urandom, $urandom}, 1);
    // race: ap_done in the expiry cycle wins
    run_txn(rand_e(), TO, 64'h1, 0);
    // done in the very first WAIT cycle
    run_txn(rand_e(), 1, {$urandom, $urandom}, 0);

    for (int n = 0; n < 10; n++) begin
      run_txn(rand_e(), int'($urandom_range(0, TO + 2)), {$urandom, $urandom},
              int'($urandom_range(0, 4)));
    end

    // reset during WAIT discards the operation
    set_e(rand_e());
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    chk("midop_in_wait", 64'(hb_start), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midop_hb_start", 64'(hb_start), 64'd0);
    chk("midop_busy", 64'(busy), 64'd0);
    chk("midop_req_ready", 64'(req_ready), 64'd1);
    chk("midop_resp_valid", 64'(resp_valid), 64'd0);
    hb_done   = 1'b1;
    hb_return = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    hb_done = 1'b0;
    step();
    step();
    chk("late_done_resp_valid", 64'(resp_valid), 64'd0);

    // stray done in IDLE has no effect
    hb_done   = 1'b1;
    hb_return = 64'h1234_5678_9ABC_DEF0;
    step();
    hb_done = 1'b0;
    step();
    chk("stray_req_ready", 64'(req_ready), 64'd1);
    chk("stray_ctrl", {60'd0, busy, hb_start, resp_valid, timeout}, 64'd0);
    chk("stray_resp", {resp_hi, resp_lo}, 64'd0);
    chk_e("stray_hb_e", hbe, '0);
    run_txn(rand_e(), 2, {$urandom, $urandom}, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
